instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction-fetch stage directly upstream of `Control_Unit` in the RISC-V processing element. Owns the program counter and issues word reads to instruction memory over a request/response handshake. Holds the returned word in an instruction register and presents the decoded fields (`Op`, `funct3`, `funct7`, register indices) to `Control_Unit` under a valid/ready handshake. Consumes `PCSrc` and the branch target to select the next PC.

## Interface
- `XLEN`, 32: address/data width.
- `RESET_PC`, 32'h0000_0000: PC after reset; must be word-aligned.
- `NOP_INSTR`, 32'h0000_0013: instruction-register reset value (`addi x0,x0,0`).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `imem_req` out 1: fetch request.
- `imem_addr` out XLEN: fetch address, equal to current PC.
- `imem_ready` in 1: memory accepts request this cycle.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in 32: instruction word.
- `instr_valid` out 1: decoded fields valid for downstream.
- `instr_ready` in 1: downstream consumes instruction this cycle.
- `PCSrc` in 1: take `PCTarget` (from `Control_Unit`, sampled only on handshake).
- `PCTarget` in XLEN: branch/jump target.
- `Instr` out 32: instruction register.
- `PC` out XLEN: address of `Instr`.
- `PCPlus4` out XLEN: `PC + 4` modulo 2^XLEN.
- `Op` out 7 `Instr[6:0]`; `rd` out 5 `[11:7]`; `funct3` out 3 `[14:12]`; `rs1` out 5 `[19:15]`; `rs2` out 5 `[24:20]`; `funct7` out 7 `[31:25]`.
- `fetch_error` out 1: sticky misaligned-target flag.
- `instr_count` out 32: instructions handed off since reset.

## Operation
- FSM states: `S_REQ`, `S_WAIT`, `S_VALID`, `S_ERR`.
- `S_REQ`: `imem_req`=1, `imem_addr`=PC. On `imem_ready`, go to `S_WAIT`.
- `S_WAIT`: `imem_req`=0. On `imem_rvalid`, load `Instr` from `imem_rdata` and go to `S_VALID`.
- `S_VALID`: `instr_valid`=1. On `instr_ready`:
  - increment `instr_count` (wraps at 2^32);
  - next PC = `PCSrc ? PCTarget : PCPlus4`;
  - go to `S_REQ`.
  - If `PCSrc`=1 and `PCTarget[1:0]`≠0: PC is unchanged, `fetch_error` is set, and the FSM goes to `S_ERR`.
- `S_ERR`: all handshake outputs are 0. The FSM stays in `S_ERR` until `rst`.
- `imem_rvalid` outside `S_WAIT` is ignored.
- `PCSrc` and `PCTarget` are ignored outside the `S_VALID`∧`instr_ready` cycle.
- While `instr_valid`=1 and `instr_ready`=0, every output is held stable and no new request is issued.
- PC arithmetic is unsigned modulo 2^XLEN: `32'hFFFF_FFFC + 4` = 0.

## Timing
- Reset values: FSM=`S_REQ`, PC=`RESET_PC`, `Instr`=`NOP_INSTR` (so `Op`=7'b0010011 and all other fields 0), `instr_valid`=0, `fetch_error`=0, `instr_count`=0. `imem_req`=1 in the first cycle after reset deasserts.
- Reset asserted mid-operation (any state) forces the reset values immediately, with no clock needed. An outstanding memory response is dropped.
- Minimum per-instruction latency is 3 cycles: REQ accepted (cycle 0), `rvalid` (cycle ≥1), `instr_valid` (cycle ≥2), next REQ the cycle after the handshake.
- The `rvalid` is never accepted in the same cycle as the request is accepted.
- Decoded fields are registered; they change only on the `S_WAIT` capture edge.
- `PCSrc` may be combinational from `Control_Unit`. It has no path back to `instr_valid` or the fields, so there is no combinational loop.

## Structure
- Shared header `rv_defs.vh` holds:
  - opcode constants (`OP_R`=0110011, `OP_I`=0010011, `OP_LOAD`=0000011, `OP_STORE`=0100011, `OP_BRANCH`=1100011);
  - `NOP_INSTR`;
  - FSM state encodings (2-bit).
- One natural sub-module, `pc_register`: the PC flop with async reset to `RESET_PC`, load enable, next-PC mux and `+4` adder. The FSM, instruction register and counter stay in `instr_fetch_unit`.

## Test plan
- **Reset:** assert `rst` → PC=0, `Instr`=0x00000013, `instr_valid`=0, `imem_req`=1 after release.
- **Sequential fetch:** memory returns 0x002081B3 at address 0 with `ready`/`rvalid` single-cycle → `Op`=0110011, `rd`=3, `rs1`=1, `rs2`=2, `funct3`=0, `funct7`=0. After the handshake with `PCSrc`=0, `imem_addr`=0x4 and `instr_count`=1.
- **Taken branch:** BEQ at 0x8, `PCSrc`=1, `PCTarget`=0x40 on handshake → next `imem_addr`=0x40, `PC` reads 0x40 at the next valid.
- **Back-pressure:** `instr_ready`=0 for 5 cycles in `S_VALID` → outputs constant, `imem_req`=0 throughout, `instr_count` unchanged.
- **Misaligned target:** `PCSrc`=1, `PCTarget`=0x42 → `fetch_error`=1, `imem_req` stays 0 for 20 cycles; `rst` clears it.
- **Reset mid-fetch and wrap:** `rst` in `S_WAIT` then a late `rvalid` with 0xDEADBEEF → `Instr` stays 0x13. With `RESET_PC`=0xFFFFFFFC, the second fetch address is 0x0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared RISC-V definitions for the fetch stage: opcodes, the reset NOP word
// and the fetch FSM state encoding.
package instr_fetch_unit_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'b00,
        S_WAIT  = 2'b01,
        S_VALID = 2'b10,
        S_ERR   = 2'b11
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter: async-reset flop with load enable, next-PC select between
// the sequential PC+4 and the redirect target.
module instr_fetch_unit_pc_register #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    logic [XLEN-1:0] pc_next;

    // Unsigned add wraps naturally at 2^XLEN.
    assign pc_plus4 = pc + XLEN'(4);
    assign pc_next  = pc_src ? pc_target : pc_plus4;

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: request/response to instruction memory, instruction
// register with decoded fields, valid/ready hand-off to the control unit.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = NOP_WORD
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [6:0]      Op,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic            fetch_error,
    output logic [31:0]     instr_count
);

    fetch_state_e state, next_state;
    logic         handshake;
    logic         misaligned;
    logic         pc_load;

    // A redirect to a non-word address freezes the stage instead of fetching.
    assign misaligned = PCSrc && !is_word_aligned(PCTarget[1:0]);
    assign pc_load    = handshake && !misaligned;

    instr_fetch_unit_pc_register #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load),
        .pc_src    (PCSrc),
        .pc_target (PCTarget),
        .pc        (PC),
        .pc_plus4  (PCPlus4)
    );

    assign imem_addr = PC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        next_state  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        handshake   = 1'b0;
        case (state)
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ready) next_state = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) next_state = S_VALID;
            end
            S_VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    handshake  = 1'b1;
                    next_state = misaligned ? S_ERR : S_REQ;
                end
            end
            S_ERR: begin
                next_state = S_ERR;
            end
            default: next_state = S_REQ;
        endcase
    end

    // NOTE: the instruction register is a real register with a defined reset
    // value (a NOP), not a memory, so it is reset like any other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Instr       <= NOP_INSTR;
            instr_count <= '0;
            fetch_error <= 1'b0;
        end else begin
            if (state == S_WAIT && imem_rvalid) Instr <= imem_rdata;
            if (handshake) instr_count <= instr_count + 32'd1;
            if (handshake && misaligned) fetch_error <= 1'b1;
        end
    end

    assign Op     = Instr[6:0];
    assign rd     = Instr[11:7];
    assign funct3 = Instr[14:12];
    assign rs1    = Instr[19:15];
    assign rs2    = Instr[24:20];
    assign funct7 = Instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table-driven fetch vectors plus
// directed sequences for back-pressure, misaligned redirect, reset and PC wrap.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [6:0]  Op;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic        fetch_error;
    logic [31:0] instr_count;

    // Second instance for the PC wrap case.
    logic        w_rst;
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_imem_ready;
    logic        w_imem_rvalid;
    logic [31:0] w_imem_rdata;
    logic        w_instr_valid;
    logic        w_instr_ready;
    logic        w_PCSrc;
    logic [31:0] w_PCTarget;
    logic [31:0] w_Instr;
    logic [31:0] w_PC;
    logic [31:0] w_PCPlus4;
    logic [6:0]  w_Op;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_funct7;
    logic        w_fetch_error;
    logic [31:0] w_instr_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_count;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .PCSrc(PCSrc), .PCTarget(PCTarget),
        .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
        .Op(Op), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
        .fetch_error(fetch_error), .instr_count(instr_count)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(w_rst),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(w_imem_ready),
        .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
        .PCSrc(w_PCSrc), .PCTarget(w_PCTarget),
        .Instr(w_Instr), .PC(w_PC), .PCPlus4(w_PCPlus4),
        .Op(w_Op), .rd(w_rd), .funct3(w_funct3), .rs1(w_rs1), .rs2(w_rs2), .funct7(w_funct7),
        .fetch_error(w_fetch_error), .instr_count(w_instr_count)
    );

    typedef struct {
        logic [31:0] rdata;
        int          rdy_dly;
        int          rv_dly;
        logic        pcsrc;
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic [6:0]  exp_op;
        logic [4:0]  exp_rd;
        logic [2:0]  exp_f3;
        logic [4:0]  exp_rs1;
        logic [4:0]  exp_rs2;
        logic [6:0]  exp_f7;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic wait_req();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (imem_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("req_seen", {31'd0, seen}, 32'd1);
    endtask

    // Request, memory response and field checks; leaves the DUT in S_VALID.
    task automatic fetch_to_valid(input vec_t v);
        wait_req();
        check("imem_addr", imem_addr, v.exp_pc);
        repeat (v.rdy_dly) @(negedge clk);
        check("req_held", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        check("req_low_in_wait", {31'd0, imem_req}, 32'd0);
        repeat (v.rv_dly) @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = v.rdata;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hBAD0_BAD0;
        check("instr_valid", {31'd0, instr_valid}, 32'd1);
        check("Instr", Instr, v.rdata);
        check("PC", PC, v.exp_pc);
        check("PCPlus4", PCPlus4, v.exp_pc + 32'd4);
        check("Op", {25'd0, Op}, {25'd0, v.exp_op});
        check("rd", {27'd0, rd}, {27'd0, v.exp_rd});
        check("funct3", {29'd0, funct3}, {29'd0, v.exp_f3});
        check("rs1", {27'd0, rs1}, {27'd0, v.exp_rs1});
        check("rs2", {27'd0, rs2}, {27'd0, v.exp_rs2});
        check("funct7", {25'd0, funct7}, {25'd0, v.exp_f7});
    endtask

    task automatic handoff(input logic pcsrc, input logic [31:0] target);
        instr_ready = 1'b1;
        PCSrc       = pcsrc;
        PCTarget    = target;
        @(negedge clk);
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        PCTarget    = 32'h0;
        exp_count++;
        check("instr_count", instr_count, exp_count);
    endtask

    function automatic vec_t mk(input logic [31:0] rdata, input int rdy_dly, input int rv_dly,
                                input logic pcsrc, input logic [31:0] target, input logic [31:0] exp_pc);
        vec_t v;
        v.rdata   = rdata;
        v.rdy_dly = rdy_dly;
        v.rv_dly  = rv_dly;
        v.pcsrc   = pcsrc;
        v.target  = target;
        v.exp_pc  = exp_pc;
        v.exp_op  = 7'h00;
        v.exp_rd  = 5'd0;
        v.exp_f3  = 3'd0;
        v.exp_rs1 = 5'd0;
        v.exp_rs2 = 5'd0;
        v.exp_f7  = 7'd0;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_req;
        logic any_valid;
        logic [31:0] held_instr;
        vec_t bp;

        // add x3,x1,x2 at 0, single-cycle memory
        vecs[0] = mk(32'h0020_81B3, 0, 0, 1'b0, 32'h0, 32'h0);
        vecs[0].exp_op = 7'b0110011; vecs[0].exp_rd = 5'd3; vecs[0].exp_rs1 = 5'd1; vecs[0].exp_rs2 = 5'd2;
        // addi x5,x0,7 at 4, slow ready and slow rvalid
        vecs[1] = mk(32'h0070_0293, 2, 3, 1'b0, 32'h0, 32'h4);
        vecs[1].exp_op = 7'b0010011; vecs[1].exp_rd = 5'd5; vecs[1].exp_rs2 = 5'd7;
        // beq x1,x2,+56 at 8, taken to 0x40
        vecs[2] = mk(32'h0220_8C63, 0, 1, 1'b1, 32'h40, 32'h8);
        vecs[2].exp_op = 7'b1100011; vecs[2].exp_rd = 5'd24; vecs[2].exp_rs1 = 5'd1;
        vecs[2].exp_rs2 = 5'd2; vecs[2].exp_f7 = 7'd1;
        // lw x6,12(x1) at the branch target
        vecs[3] = mk(32'h00C0_A303, 1, 0, 1'b0, 32'hFFFF_FFF0, 32'h40);
        vecs[3].exp_op = 7'b0000011; vecs[3].exp_rd = 5'd6; vecs[3].exp_f3 = 3'd2;
        vecs[3].exp_rs1 = 5'd1; vecs[3].exp_rs2 = 5'd12;
        // sw x7,8(x2)
        vecs[4] = mk(32'h0071_2423, 0, 0, 1'b0, 32'h0, 32'h44);
        vecs[4].exp_op = 7'b0100011; vecs[4].exp_rd = 5'd8; vecs[4].exp_f3 = 3'd2;
        vecs[4].exp_rs1 = 5'd2; vecs[4].exp_rs2 = 5'd7;
        // sub x1,x2,x3
        vecs[5] = mk(32'h4031_00B3, 0, 2, 1'b0, 32'h0, 32'h48);
        vecs[5].exp_op = 7'b0110011; vecs[5].exp_rd = 5'd1; vecs[5].exp_rs1 = 5'd2;
        vecs[5].exp_rs2 = 5'd3; vecs[5].exp_f7 = 7'b0100000;

        rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        instr_ready = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
        w_rst = 1'b1; w_imem_ready = 1'b0; w_imem_rvalid = 1'b0; w_imem_rdata = 32'h0;
        w_instr_ready = 1'b0; w_PCSrc = 1'b0; w_PCTarget = 32'h0;
        exp_count = 0;

        // Reset values
        #1;
        check("rst_PC", PC, 32'h0);
        check("rst_Instr", Instr, 32'h0000_0013);
        check("rst_Op", {25'd0, Op}, 32'h13);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_err", {31'd0, fetch_error}, 32'd0);
        check("rst_count", instr_count, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("req_after_rst", {31'd0, imem_req}, 32'd1);

        // Table-driven fetches
        for (int i = 0; i < 6; i++) begin
            fetch_to_valid(vecs[i]);
            handoff(vecs[i].pcsrc, vecs[i].target);
        end

        // Back-pressure with ignored redirect and stray rvalid
        bp = mk(32'h0070_0293, 0, 0, 1'b0, 32'h0, 32'h4C);
        bp.exp_op = 7'b0010011; bp.exp_rd = 5'd5; bp.exp_rs2 = 5'd7;
        fetch_to_valid(bp);
        held_instr = Instr;
        for (int c = 0; c < 5; c++) begin
            PCSrc = 1'b1;
            PCTarget = 32'h42;
            imem_rvalid = (c == 2);
            imem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            check("bp_req", {31'd0, imem_req}, 32'd0);
            check("bp_valid", {31'd0, instr_valid}, 32'd1);
            check("bp_Instr", Instr, held_instr);
            check("bp_PC", PC, 32'h4C);
            check("bp_count", instr_count, exp_count);
            check("bp_err", {31'd0, fetch_error}, 32'd0);
        end
        imem_rvalid = 1'b0;
        handoff(1'b0, 32'h0);

        // Misaligned redirect
        bp.exp_pc = 32'h50;
        fetch_to_valid(bp);
        instr_ready = 1'b1; PCSrc = 1'b1; PCTarget = 32'h42;
        @(negedge clk);
        instr_ready = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
        check("err_set", {31'd0, fetch_error}, 32'd1);
        check("err_PC", PC, 32'h50);
        any_req = 1'b0;
        any_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            imem_ready = 1'b1;
            imem_rvalid = 1'b1;
            instr_ready = 1'b1;
            @(negedge clk);
            any_req = any_req | imem_req;
            any_valid = any_valid | instr_valid;
        end
        imem_ready = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
        check("err_no_req", {31'd0, any_req}, 32'd0);
        check("err_no_valid", {31'd0, any_valid}, 32'd0);
        check("err_sticky", {31'd0, fetch_error}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("err_cleared", {31'd0, fetch_error}, 32'd0);
        check("err_rst_PC", PC, 32'h0);
        check("err_rst_count", instr_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;

        // Reset while waiting for the response, then a late rvalid
        wait_req();
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        check("mid_in_wait", {31'd0, imem_req}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_Instr", Instr, 32'h0000_0013);
        check("mid_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("late_rvalid_Instr", Instr, 32'h0000_0013);
        check("late_rvalid_valid", {31'd0, instr_valid}, 32'd0);
        check("late_rvalid_req", {31'd0, imem_req}, 32'd1);
        check("late_rvalid_addr", imem_addr, 32'h0);

        // PC wrap with RESET_PC = 0xFFFFFFFC
        @(negedge clk);
        w_rst = 1'b0;
        @(negedge clk);
        check("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
        check("wrap_req0", {31'd0, w_imem_req}, 32'd1);
        w_imem_ready = 1'b1;
        @(negedge clk);
        w_imem_ready = 1'b0;
        w_imem_rvalid = 1'b1;
        w_imem_rdata = 32'h0000_0013;
        @(negedge clk);
        w_imem_rvalid = 1'b0;
        check("wrap_valid", {31'd0, w_instr_valid}, 32'd1);
        check("wrap_PCPlus4", w_PCPlus4, 32'h0);
        w_instr_ready = 1'b1;
        @(negedge clk);
        w_instr_ready = 1'b0;
        check("wrap_addr1", w_imem_addr, 32'h0);
        check("wrap_req1", {31'd0, w_imem_req}, 32'd1);
        check("wrap_count", w_instr_count, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
